// File: rtl/long_divider_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | long_divider_top: iterative restoring divider, 2N/N -> 2N quotient,      |
// | N remainder. Optional err_o under LONG_DIVIDER_ERR_EN. Revision: 1.0     |
// +--------------------------------------------------------------------------+
module long_divider_top #(
  parameter int DATA_LENGTH    = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     finish_o,
`ifdef LONG_DIVIDER_ERR_EN
  output logic                     err_o,
`endif
  input  logic [2*DATA_LENGTH-1:0] indata_n_i,
  input  logic [DATA_LENGTH-1:0]   indata_d_i,
  output logic [2*DATA_LENGTH-1:0] outdata_q_o,
  output logic [DATA_LENGTH-1:0]   outdata_r_o
);

  localparam int c_nw    = 2 * DATA_LENGTH;
  localparam int c_iters = c_nw / BITS_PER_CYCLE;
  localparam int c_cw    = $clog2(c_iters + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_FINISH  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DATA_LENGTH:0]   r_rem;
  logic [c_nw-1:0]        r_quo;
  logic [DATA_LENGTH-1:0] r_div;
  logic [c_cw-1:0]        r_cnt;
  logic [c_nw-1:0]        r_q_out;
  logic [DATA_LENGTH-1:0] r_r_out;
  logic [DATA_LENGTH:0]   w_rem_nxt;
  logic [c_nw-1:0]        w_quo_nxt;
  logic                   w_div_zero;
  logic                   w_last;

  assign w_div_zero  = (indata_d_i == '0);
  assign w_last      = (r_cnt == c_cw'(1));
  assign outdata_q_o = r_q_out;
  assign outdata_r_o = r_r_out;

  // One compute cycle: BITS_PER_CYCLE restoring steps chained MSB first.
  always_comb begin : p_steps
    logic [DATA_LENGTH:0]   w_rem_t;
    logic [c_nw-1:0]        w_quo_t;
    logic [DATA_LENGTH+1:0] w_shift;
    logic [DATA_LENGTH:0]   w_diff;
    logic                   w_ge;
    w_rem_t = r_rem;
    w_quo_t = r_quo;
    w_shift = '0;
    w_diff  = '0;
    w_ge    = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_shift = {w_rem_t, w_quo_t[c_nw-1]};
      w_ge    = (w_shift >= {2'b00, r_div});
      w_diff  = w_shift[DATA_LENGTH:0] - {1'b0, r_div};
      w_quo_t = {w_quo_t[c_nw-2:0], w_ge};
      w_rem_t = w_ge ? w_diff : w_shift[DATA_LENGTH:0];
    end
    w_rem_nxt = w_rem_t;
    w_quo_nxt = w_quo_t;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b0;
    finish_o    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = w_div_zero ? S_FINISH : S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        busy_o = 1'b1;
        if (w_last) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        finish_o    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_q_out <= '0;
      r_r_out <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_quo <= indata_n_i;
            r_div <= indata_d_i;
            r_rem <= '0;
            r_cnt <= c_cw'(c_iters);
            if (w_div_zero) begin
              r_q_out <= '1;
              r_r_out <= indata_n_i[DATA_LENGTH-1:0];
            end
          end
        end
        S_COMPUTE: begin
          r_quo <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt - c_cw'(1);
          if (w_last) begin
            r_q_out <= w_quo_nxt;
            r_r_out <= w_rem_nxt[DATA_LENGTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LONG_DIVIDER_ERR_EN
  logic r_err;

  // Flag follows the divisor of the most recently accepted operation.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && start_i) begin
      r_err <= w_div_zero;
    end
  end

  assign err_o = r_err;
`endif

endmodule
`default_nettype wire
